frame_energy: RTL and testbench

FRAME_ENERGY -- requirements
Module: frame_energy

---
 rtl/frame_energy_pkg.sv | 14 +
 rtl/frame_energy_vad_hangover.sv | 51 +++++
 rtl/frame_energy.sv | 129 ++++++++++++
 tb/tb_frame_energy.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/frame_energy_pkg.sv
// Shared speech-pipeline definitions: frame accumulator state encoding and
// the width of the frame energy datapath.
package frame_energy_pkg;

  // IDLE: no partial frame held. ACCUM: a partial frame is being summed.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fe_state_e;

  // Frame energy width; 65536 samples of 65535 still fit without overflow.
  localparam int ENERGY_W = 32;

endpackage : frame_energy_pkg

// File: rtl/frame_energy_vad_hangover.sv
// Voice-activity decision with hangover: speech stays asserted for a number
// of quiet frames after the last frame whose energy reached the threshold.
module vad_hangover
  import frame_energy_pkg::*;
#(
  parameter logic [ENERGY_W-1:0] THRESHOLD = 32'd1_000_000,
  parameter int                  HANGOVER  = 4
) (
  input  logic                iclk,
  input  logic                irstn,
  input  logic                iframe,   // frame completes at this edge
  input  logic [ENERGY_W-1:0] ienergy,  // energy of the completing frame
  output logic                ospeech
);

  localparam logic [7:0] HANG_INIT = 8'(HANGOVER);

  logic [7:0] hang_q, hang_d;
  logic       speech_q, speech_d;

  // Decide speech level and remaining hangover for the completing frame.
  always_comb begin
    hang_d   = hang_q;
    speech_d = speech_q;
    if (iframe) begin
      if (ienergy >= THRESHOLD) begin
        speech_d = 1'b1;
        hang_d   = HANG_INIT;
      end else if (hang_q != 8'd0) begin
        speech_d = 1'b1;
        hang_d   = hang_q - 8'd1;
      end else begin
        speech_d = 1'b0;
      end
    end
  end

  // Hangover counter and speech level registers.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      hang_q   <= 8'd0;
      speech_q <= 1'b0;
    end else begin
      hang_q   <= hang_d;
      speech_q <= speech_d;
    end
  end

  assign ospeech = speech_q;

endmodule : vad_hangover

// File: rtl/frame_energy.sv
// Frame energy accumulator: sums FRAME_LEN contiguous-index magnitudes into
// one energy result per frame, discards frames broken by an index gap, and
// drives a voice-activity flag with hangover.
module frame_energy
  import frame_energy_pkg::*;
#(
  parameter int                  FRAME_LEN = 256,
  parameter logic [ENERGY_W-1:0] THRESHOLD = 32'd1_000_000,
  parameter int                  HANGOVER  = 4
) (
  input  logic                iclk,
  input  logic                irstn,
  input  logic                ivalid,
  input  logic [31:0]         iidx,
  input  logic [15:0]         idata,
  output logic                oframe_valid,
  output logic [ENERGY_W-1:0] oenergy,
  output logic [31:0]         ostart_idx,
  output logic [15:0]         oframe_num,
  output logic                ospeech,
  output logic                odrop
);

  // One extra bit so the count can hold FRAME_LEN itself.
  localparam int               CNT_W    = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

  fe_state_e           state_q, state_d;
  logic [ENERGY_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         start_q, start_d;
  logic [31:0]         exp_q, exp_d;
  logic                frame_valid_q, frame_valid_d;
  logic [ENERGY_W-1:0] energy_q, energy_d;
  logic [31:0]         start_idx_q, start_idx_d;
  logic [15:0]         frame_num_q, frame_num_d;
  logic                drop_q, drop_d;

  // A sample opens a fresh frame when nothing is held or its index breaks
  // the contiguous run; otherwise it extends the held partial frame.
  logic                new_frame;
  logic [ENERGY_W-1:0] sum_w;
  logic [CNT_W-1:0]    cnt_w;
  logic [31:0]         first_idx_w;

  assign new_frame   = (state_q == IDLE) || (iidx != exp_q);
  assign sum_w       = new_frame ? {16'd0, idata} : acc_q + {16'd0, idata};
  assign cnt_w       = new_frame ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign first_idx_w = new_frame ? iidx : start_q;

  // Next-state: accept sample, detect gaps, and publish completed frames.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    exp_d         = exp_q;
    frame_valid_d = 1'b0;
    drop_d        = 1'b0;
    energy_d      = energy_q;
    start_idx_d   = start_idx_q;
    frame_num_d   = frame_num_q;
    if (ivalid) begin
      drop_d = (state_q == ACCUM) && (iidx != exp_q);
      exp_d  = iidx + 32'd1;
      if (cnt_w == CNT_FULL) begin
        state_d       = IDLE;
        acc_d         = '0;
        cnt_d         = '0;
        start_d       = first_idx_w;
        frame_valid_d = 1'b1;
        energy_d      = sum_w;
        start_idx_d   = first_idx_w;
        frame_num_d   = frame_num_q + 16'd1;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_w;
        cnt_d   = cnt_w;
        start_d = first_idx_w;
      end
    end
  end

  // State and result registers; reset drops any partial frame silently.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      start_q       <= '0;
      exp_q         <= '0;
      frame_valid_q <= 1'b0;
      energy_q      <= '0;
      start_idx_q   <= '0;
      frame_num_q   <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      exp_q         <= exp_d;
      frame_valid_q <= frame_valid_d;
      energy_q      <= energy_d;
      start_idx_q   <= start_idx_d;
      frame_num_q   <= frame_num_d;
      drop_q        <= drop_d;
    end
  end

  // Fed with the completion strobe so speech changes alongside oframe_valid.
  vad_hangover #(
    .THRESHOLD (THRESHOLD),
    .HANGOVER  (HANGOVER)
  ) u_vad_hangover (
    .iclk    (iclk),
    .irstn   (irstn),
    .iframe  (frame_valid_d),
    .ienergy (energy_d),
    .ospeech (ospeech)
  );

  assign oframe_valid = frame_valid_q;
  assign oenergy      = energy_q;
  assign ostart_idx   = start_idx_q;
  assign oframe_num   = frame_num_q;
  assign odrop        = drop_q;

endmodule : frame_energy

// File: tb/tb_frame_energy.sv
// Directed bench for frame_energy with FRAME_LEN=4, THRESHOLD=100, HANGOVER=2.
module tb_frame_energy;

  logic        iclk = 1'b0;
  logic        irstn = 1'b0;
  logic        ivalid = 1'b0;
  logic [31:0] iidx = '0;
  logic [15:0] idata = '0;
  logic        oframe_valid;
  logic [31:0] oenergy;
  logic [31:0] ostart_idx;
  logic [15:0] oframe_num;
  logic        ospeech;
  logic        odrop;

  int n_vec = 0;
  int n_err = 0;

  frame_energy #(
    .FRAME_LEN (4),
    .THRESHOLD (32'd100),
    .HANGOVER  (2)
  ) dut (
    .iclk         (iclk),
    .irstn        (irstn),
    .ivalid       (ivalid),
    .iidx         (iidx),
    .idata        (idata),
    .oframe_valid (oframe_valid),
    .oenergy      (oenergy),
    .ostart_idx   (ostart_idx),
    .oframe_num   (oframe_num),
    .ospeech      (ospeech),
    .odrop        (odrop)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic        v;
    logic [31:0] idx;
    logic [15:0] d;
    logic        fv;
    logic [31:0] en;
    logic [31:0] st;
    logic [15:0] num;
    logic        sp;
    logic        dr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [31:0] idx, input logic [15:0] d,
                     input logic fv, input logic [31:0] en, input logic [31:0] st,
                     input logic [15:0] num, input logic sp, input logic dr);
    vec_t e;
    e.v = v; e.idx = idx; e.d = d; e.fv = fv; e.en = en; e.st = st;
    e.num = num; e.sp = sp; e.dr = dr;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one sample (or idle) at the falling edge, sample results after the
  // following rising edge.
  task automatic step(input logic v, input logic [31:0] idx, input logic [15:0] d);
    @(negedge iclk);
    ivalid = v;
    iidx   = idx;
    idata  = d;
    @(posedge iclk);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic fv, input logic [31:0] en,
                         input logic [31:0] st, input logic [15:0] num,
                         input logic sp, input logic dr);
    chk({tag, ".fv"},  32'(oframe_valid), 32'(fv));
    chk({tag, ".en"},  oenergy, en);
    chk({tag, ".st"},  ostart_idx, st);
    chk({tag, ".num"}, 32'(oframe_num), 32'(num));
    chk({tag, ".sp"},  32'(ospeech), 32'(sp));
    chk({tag, ".dr"},  32'(odrop), 32'(dr));
    $display("%s: v=%0b idx=%0h -> fv=%0b en=%0d st=%0h num=%0d sp=%0b dr=%0b",
             tag, ivalid, iidx, oframe_valid, oenergy, ostart_idx, oframe_num,
             ospeech, odrop);
  endtask

  initial begin
    // Contiguous frame, energy exactly at threshold.
    add(1, 0, 10, 0,   0, 0, 0, 0, 0);
    add(1, 1, 20, 0,   0, 0, 0, 0, 0);
    add(1, 2, 30, 0,   0, 0, 0, 0, 0);
    add(1, 3, 40, 1, 100, 0, 1, 1, 0);
    // Back-to-back quiet frames consume the hangover, third drops speech.
    for (int i = 4; i < 16; i++) begin
      if (i % 4 != 3)
        add(1, 32'(i), 1, 0, (i < 8) ? 32'd100 : 32'd4, (i < 8) ? 32'd0 : 32'((i / 4) * 4 - 4),
            16'((i / 4)), 1'b1, 0);
      else
        add(1, 32'(i), 1, 1, 4, 32'(i - 3), 16'((i / 4) + 1), (i < 15), 0);
    end
    // Index gap: 20,21 discarded at 23, frame 23..26 completes.
    add(1, 20, 5, 0,  4, 12, 4, 0, 0);
    add(1, 21, 5, 0,  4, 12, 4, 0, 0);
    add(1, 23, 7, 0,  4, 12, 4, 0, 1);
    add(1, 24, 7, 0,  4, 12, 4, 0, 0);
    add(1, 25, 7, 0,  4, 12, 4, 0, 0);
    add(1, 26, 7, 1, 28, 23, 5, 0, 0);
    add(0,  0, 0, 0, 28, 23, 5, 0, 0);

    // Reset state.
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge iclk);
    irstn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].idx, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].fv, tbl[i].en, tbl[i].st,
              tbl[i].num, tbl[i].sp, tbl[i].dr);
    end

    // Asynchronous reset in the middle of a partial frame.
    step(1, 0, 9);
    chk_all("prerst0", 0, 28, 23, 5, 0, 0);
    step(1, 1, 9);
    chk_all("prerst1", 0, 28, 23, 5, 0, 0);
    #2 irstn = 1'b0;
    #1;
    chk_all("asyncrst", 0, 0, 0, 0, 0, 0);
    @(negedge iclk);
    irstn = 1'b1;
    for (int i = 50; i < 53; i++) begin
      step(1, 32'(i), 1);
      chk_all($sformatf("rst_idx%0d", i), 0, 0, 0, 0, 0, 0);
    end
    step(1, 53, 1);
    chk_all("rst_idx53", 1, 4, 50, 1, 0, 0);

    // Index wrap across 2^32 is still contiguous.
    step(1, 32'hFFFF_FFFE, 16'hFFFF);
    chk_all("wrap0", 0, 4, 50, 1, 0, 0);
    step(1, 32'hFFFF_FFFF, 16'hFFFF);
    chk_all("wrap1", 0, 4, 50, 1, 0, 0);
    step(1, 32'h0, 16'hFFFF);
    chk_all("wrap2", 0, 4, 50, 1, 0, 0);
    step(1, 32'h1, 16'hFFFF);
    chk_all("wrap3", 1, 262140, 32'hFFFF_FFFE, 2, 1, 0);

    // Random idle gaps between samples must not change the result.
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        step(0, 0, 0);
        chk_all($sformatf("gap%0d_%0d", i, g), 0,
                262140, 32'hFFFF_FFFE, 2, 1, 0);
      end
      step(1, 32'(i), 16'((i + 1) * 10));
      if (i < 3)
        chk_all($sformatf("gap_idx%0d", i), 0, 262140, 32'hFFFF_FFFE, 2, 1, 0);
      else
        chk_all("gap_idx3", 1, 100, 0, 3, 1, 0);
    end
    step(0, 0, 0);
    chk_all("gap_after", 0, 100, 0, 3, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_frame_energy
